// File: rtl/branch_predictor_dyn_if.sv
// Fetch/execute-side bundle for the dynamic branch predictor: lookup lanes, resolution feedback, prediction.
// HW is the stored history width, i.e. max(HIST_W,1) of the predictor it connects to.
interface branch_predictor_dyn_if #(
  parameter int HW = 1
);
  logic [3:0]    brnch_pc_sel_from_bhndlr;
  logic          update_bpred;
  logic          loop_start;
  logic [15:0]   pc;
  logic [15:0]   pc_plus1;
  logic [15:0]   pc_plus2;
  logic [15:0]   pc_plus3;
  logic          resolve_valid;
  logic [15:0]   resolve_pc;
  logic          resolve_taken;
  logic          resolve_mispred;
  logic [HW-1:0] resolve_hist;
  logic [1:0]    pred_to_pcsel;
  logic [HW-1:0] pred_hist;

  modport master (
    output brnch_pc_sel_from_bhndlr, update_bpred, loop_start,
           pc, pc_plus1, pc_plus2, pc_plus3,
           resolve_valid, resolve_pc, resolve_taken, resolve_mispred, resolve_hist,
    input  pred_to_pcsel, pred_hist
  );

  modport slave (
    input  brnch_pc_sel_from_bhndlr, update_bpred, loop_start,
           pc, pc_plus1, pc_plus2, pc_plus3,
           resolve_valid, resolve_pc, resolve_taken, resolve_mispred, resolve_hist,
    output pred_to_pcsel, pred_hist
  );
endinterface

// File: rtl/branch_predictor_dyn.sv
// Bimodal/gshare saturating-counter branch predictor feeding the fetch PC-select mux.
// Latency: prediction combinational, training/history visible next cycle; no backpressure.
module branch_predictor_dyn #(
  parameter int IDX_W  = 6,
  parameter int CTR_W  = 2,
  parameter int HIST_W = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  branch_predictor_dyn_if.slave bp
);
  localparam int HW    = (HIST_W > 0) ? HIST_W : 1;
  localparam int DEPTH = 1 << IDX_W;
  localparam logic [CTR_W-1:0] CTR_INIT = {1'b1, {(CTR_W-1){1'b0}}};
  localparam logic [CTR_W-1:0] CTR_MAX  = '1;
  localparam logic [CTR_W-1:0] CTR_ZERO = '0;

  logic [CTR_W-1:0] ctr_tbl [DEPTH];
  logic [HW-1:0]    ghr;
  logic [15:0]      sel_pc;
  logic             lane_vld;
  logic             pred_vld;
  logic             pred_taken;
  logic             spec_shift;
  logic             recover;
  logic [IDX_W-1:0] hist_pad;
  logic [IDX_W-1:0] rhist_pad;
  logic [IDX_W-1:0] lk_idx;
  logic [IDX_W-1:0] tr_idx;
  logic [CTR_W-1:0] lk_ctr;
  logic [CTR_W-1:0] tr_ctr;
  logic [CTR_W-1:0] tr_ctr_nxt;
  logic [HW:0]      ghr_spec_ext;
  logic [HW:0]      ghr_rec_ext;
  logic             unused_bits;

  // Lowest set lane bit wins.
  always_comb begin
    sel_pc = bp.pc;
    casez (bp.brnch_pc_sel_from_bhndlr)
      4'b???1: sel_pc = bp.pc;
      4'b??10: sel_pc = bp.pc_plus1;
      4'b?100: sel_pc = bp.pc_plus2;
      4'b1000: sel_pc = bp.pc_plus3;
      default: sel_pc = bp.pc;
    endcase
  end

  assign lane_vld   = |bp.brnch_pc_sel_from_bhndlr;
  assign pred_vld   = bp.update_bpred & lane_vld;
  assign hist_pad   = (HIST_W > 0) ? IDX_W'(ghr) : '0;
  assign rhist_pad  = (HIST_W > 0) ? IDX_W'(bp.resolve_hist) : '0;
  assign lk_idx     = sel_pc[IDX_W-1:0] ^ hist_pad;
  assign tr_idx     = bp.resolve_pc[IDX_W-1:0] ^ rhist_pad;
  assign lk_ctr     = ctr_tbl[lk_idx];
  assign tr_ctr     = ctr_tbl[tr_idx];
  assign pred_taken = lk_ctr[CTR_W-1];

  always_comb begin
    bp.pred_to_pcsel = 2'b00;
    if (pred_vld) begin
      if (bp.loop_start) bp.pred_to_pcsel = 2'b11;
      else               bp.pred_to_pcsel = {1'b0, pred_taken};
    end
  end

  always_comb begin
    tr_ctr_nxt = tr_ctr;
    if (bp.resolve_taken && tr_ctr != CTR_MAX)       tr_ctr_nxt = tr_ctr + 1'b1;
    else if (!bp.resolve_taken && tr_ctr != CTR_ZERO) tr_ctr_nxt = tr_ctr - 1'b1;
  end

  // Shift-in via concatenation keeps HW=1 legal without a separate generate branch.
  assign ghr_spec_ext = {ghr, pred_taken};
  assign ghr_rec_ext  = {bp.resolve_hist, bp.resolve_taken};
  assign spec_shift   = (HIST_W > 0) && pred_vld && !bp.loop_start;
  assign recover      = (HIST_W > 0) && bp.resolve_valid && bp.resolve_mispred;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) ctr_tbl[i] <= CTR_INIT;
      ghr <= '0;
    end else begin
      if (bp.resolve_valid) ctr_tbl[tr_idx] <= tr_ctr_nxt;
      if (recover)         ghr <= ghr_rec_ext[HW-1:0];
      else if (spec_shift) ghr <= ghr_spec_ext[HW-1:0];
    end
  end

  assign bp.pred_hist = ghr;

  assign unused_bits = ^{sel_pc[15:IDX_W], bp.resolve_pc[15:IDX_W],
                         ghr_spec_ext[HW], ghr_rec_ext[HW], lk_ctr};
endmodule

// File: doc/branch_predictor_dyn.md
# branch_predictor_dyn

Parametrised dynamic branch predictor: the successor to the static always-taken predictor in the fetch stage. Holds a table of saturating counters indexed by branch PC, optionally XOR-ed with a global history register (gshare). Produces the same 2-bit `pred_to_pcsel` code the PC-select mux already consumes. The execute-stage branch resolution trains it.

## Interface
- `IDX_W`, 6: table index width; the table has 2^IDX_W entries.
- `CTR_W`, 2: counter width, 2..4.
- `HIST_W`, 0: global history width. 0 selects pure bimodal; 1..IDX_W selects gshare.
- `clk`  in  1  clock, all state updates on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `brnch_pc_sel_from_bhndlr`  in  4  branch-lane mask from the branch handler. Bit0 = `pc`, bit1 = `pc_plus1`, bit2 = `pc_plus2`, bit3 = `pc_plus3`.
- `update_bpred`  in  1  a branch is present in the fetch bundle; a prediction is required.
- `loop_start`  in  1  the branch is a loop-start branch; forces a taken-loop prediction.
- `pc`, `pc_plus1`, `pc_plus2`, `pc_plus3`  in  16 each  fetch-bundle PCs.
- `resolve_valid`  in  1  a branch resolved this cycle.
- `resolve_pc`  in  16  PC of the resolved branch.
- `resolve_taken`  in  1  actual outcome of the resolved branch.
- `resolve_mispred`  in  1  the prediction for the resolved branch was wrong.
- `resolve_hist`  in  max(HIST_W,1)  history snapshot returned with the branch.
- `pred_to_pcsel`  out  2  prediction code: 00 sequential / not-taken, 01 taken, 11 loop-start taken.
- `pred_hist`  out  max(HIST_W,1)  GHR value used for this prediction; carried down the pipe to come back as `resolve_hist`.

## Operation
- **Lane select**
  - The lowest set bit of `brnch_pc_sel_from_bhndlr` selects the lookup PC.
  - Mask 0 means no lane is selected: the block is treated as if `update_bpred` were 0.
- **Lookup index**
  - Bimodal: `idx = selPC[IDX_W-1:0]`.
  - Gshare: `idx = selPC[IDX_W-1:0] ^ {zero-pad, GHR}`.
- **Prediction**
  - If `update_bpred` is 0 or no lane is selected: `pred_to_pcsel` = 00.
  - Else if `loop_start` is 1: 11, whatever the counter value.
  - Else: 01 if the counter MSB is 1, otherwise 00.
- **Speculative history**
  - Applies when HIST_W>0, `update_bpred` is 1, a lane is selected, and `loop_start` is 0.
  - At the clock edge: GHR <= {GHR[HIST_W-2:0], predicted-taken bit}.
  - Loop-start predictions do not shift the GHR.
- **Training**
  - On `resolve_valid`, the entry at `resolve_pc[IDX_W-1:0] ^ resolve_hist` (bimodal: no XOR) moves +1 if taken, −1 if not.
  - The counter saturates at 2^CTR_W−1 and at 0. It never wraps.
- **Recovery**
  - On `resolve_valid & resolve_mispred` with HIST_W>0: GHR <= {resolve_hist[HIST_W-2:0], resolve_taken}.
  - Recovery has priority over the speculative shift in the same cycle.
- `resolve_mispred` without `resolve_valid` is ignored.
- `pred_hist` = current GHR, or 0 when HIST_W=0.

## Timing
- Prediction is combinational from the inputs and the table/GHR flops, in the same cycle.
- A table update is visible to lookups from the next cycle.
- Same-cycle lookup and update of the same entry: the lookup sees the pre-update value. There is no bypass.
- Reset (asynchronous, while `rst_n` is 0):
  - Every counter = 2^(CTR_W−1), i.e. weakly taken, which preserves the legacy always-taken behaviour on a cold table.
  - GHR = 0.
  - `pred_to_pcsel` follows its inputs combinationally: 11 / 01 / 00 exactly as the legacy block.
- Reset asserted mid-operation clears all state immediately. A resolve in flight during reset is dropped.
- All sequential logic is clocked only by `clk`, with `rst_n` as the only asynchronous input.

## Test plan
- **Cold-table reset, defaults:** release reset; `update_bpred`=1, mask=0001, `pc`=0x0010, `loop_start`=0 → 01. Set `loop_start`=1 → 11. Set `update_bpred`=0 → 00.
- **Saturation, defaults:** resolve `resolve_pc`=0x0010 not-taken twice → lookup at 0x0010 gives 00. A third not-taken keeps the counter at 0. Four taken resolves → counter 3 and 01. A fifth taken keeps it at 3.
- **Lane priority:** mask=0110, `pc_plus1`=0x0021 trained not-taken, `pc_plus2`=0x0022 untrained → 00, because lane 1 is used. Mask=0000 → 00 and the GHR does not change.
- **Same-cycle hazard:** lookup and not-taken resolve on the same entry (counter 2) in one cycle → output 01 that cycle, 00 the next.
- **Gshare (HIST_W=4):** three taken predictions → `pred_hist` = 0111. Then a resolve with `resolve_mispred`=1, `resolve_hist`=0011, `resolve_taken`=0, issued in the same cycle as a taken prediction → GHR = 0110.
- **Asynchronous reset mid-run:** drop `rst_n` between clock edges after training → GHR and all counters return to reset values at once. The first post-reset lookup gives 01.
